// File: rtl/qea_host_loader.sv
// Host sequencer for the QEA: streams gate context into CTX RAM, seeds STATE RAM with |0..0>,
// runs the core and streams the state vector back out. Optional RUN watchdog: QEA_HOST_TIMEOUT_EN.
module qea_host_loader #(
    parameter int unsigned PE_NUM_WIDTH            = 2,
    parameter int unsigned PE_NUM                  = 4,
    parameter int unsigned DATA_WIDTH              = 32,
    parameter int unsigned STATE_DATA_WIDTH        = 64,
    parameter int unsigned STATE_ADDR_WIDTH        = 16,
    parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int unsigned MAX_QBIT_WIDTH          = 6,
    parameter int unsigned NUM_FRAC_BIT            = 30,
    parameter int unsigned TIMEOUT_CYCLES          = 32'd16777216
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     i_ins_num,
    input  logic                                   i_ctx_valid,
    output logic                                   o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]     i_ctx_data,
    output logic                                   o_ctx_en,
    output logic                                   o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]     o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]     o_ctx_data,
    output logic                                   o_state_ena,
    output logic                                   o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_state_dina,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout,
    output logic                                   o_start,
    input  logic                                   i_complete,
    output logic                                   o_rd_valid,
    input  logic                                   i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]     o_rd_data,
    output logic                                   o_rd_last,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_err,
    output logic [31:0]                            o_cycles
);
    localparam int unsigned SAW  = STATE_ADDR_WIDTH;
    localparam int unsigned GCAW = GATE_CONTEXT_ADDR_WIDTH;
    localparam int unsigned MQW  = MAX_QBIT_WIDTH;
    localparam int unsigned SW   = PE_NUM * STATE_DATA_WIDTH;
    localparam int unsigned NW   = SAW + 1;
    localparam int unsigned ONE_BIT = (PE_NUM - 1) * STATE_DATA_WIDTH
                                    + (STATE_DATA_WIDTH - DATA_WIDTH) + NUM_FRAC_BIT;
    localparam logic [SW-1:0] INIT_WORD = SW'(1) << ONE_BIT;

    typedef enum logic [3:0] {
        S_IDLE, S_CTX, S_INIT, S_START, S_RUN, S_RD_ADDR, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SAW-1:0]    k_q, k_d;
    logic [GCAW-1:0]   beats_q, beats_d;
    logic [GCAW-1:0]   ins_q;
    logic [MQW-1:0]    qbit_q;
    logic [31:0]       cycles_d;

    logic              bad_go_c, last_beat_c, timeout_c, ctx_beat_c;
    logic [MQW-1:0]    shift_c;
    logic [NW-1:0]     n_words_c;
    logic [SAW-1:0]    n_last_c;
    logic [31:0]       cyc_inc_c;

    logic busy_d, ctx_ready_d, start_d, done_d, err_d, ctx_we_d;
    logic st_ena_d, st_wea_d, rd_valid_d, rd_last_d;
    logic [SW-1:0] st_din_d;

    // N-1 computed one bit wider so that N = 2**SAW lands on all-ones
    assign shift_c     = qbit_q - MQW'(PE_NUM_WIDTH);
    assign n_words_c   = NW'(1) << shift_c;
    assign n_last_c    = SAW'(n_words_c - NW'(1));
    assign bad_go_c    = (i_qbit_num < MQW'(PE_NUM_WIDTH)) ||
                         (i_qbit_num > MQW'(SAW + PE_NUM_WIDTH));
    assign last_beat_c = (beats_q == ins_q - GCAW'(1));
    assign ctx_beat_c  = (state_q == S_CTX) && i_ctx_valid && o_ctx_ready;
    assign cyc_inc_c   = (&o_cycles) ? o_cycles : o_cycles + 32'd1;
`ifdef QEA_HOST_TIMEOUT_EN
    assign timeout_c   = (state_q == S_RUN) && (cyc_inc_c == 32'(TIMEOUT_CYCLES));
`else
    assign timeout_c   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            beats_q  <= '0;
            ins_q    <= '0;
            qbit_q   <= '0;
            o_cycles <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            beats_q  <= beats_d;
            o_cycles <= cycles_d;
            if (state_q == S_IDLE && i_go) begin
                ins_q  <= i_ins_num;
                qbit_q <= i_qbit_num;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        beats_d  = beats_q;
        cycles_d = o_cycles;
        case (state_q)
            S_IDLE: begin
                k_d     = '0;
                beats_d = '0;
                if (i_go && !bad_go_c)
                    state_d = (i_ins_num == '0) ? S_INIT : S_CTX;
            end
            S_CTX: if (ctx_beat_c) begin
                beats_d = beats_q + GCAW'(1);
                if (last_beat_c) state_d = S_INIT;
            end
            S_INIT: begin
                if (k_q == n_last_c) begin
                    k_d     = '0;
                    state_d = S_START;
                end else begin
                    k_d = k_q + SAW'(1);
                end
            end
            S_START: begin
                cycles_d = '0;
                state_d  = S_RUN;
            end
            // the START cycle never samples i_complete, so a stale level is masked
            S_RUN: begin
                cycles_d = cyc_inc_c;
                if (i_complete)     state_d = S_RD_ADDR;
                else if (timeout_c) state_d = S_IDLE;
            end
            S_RD_ADDR: state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_RD_OUT;
            S_RD_OUT: if (i_rd_ready) begin
                if (k_q == n_last_c) begin
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + SAW'(1);
                    state_d = S_RD_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; they line up with the state they describe
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        ctx_ready_d = (state_d == S_CTX);
        start_d     = (state_d == S_START);
        done_d      = (state_d == S_DONE);
        err_d       = (state_q == S_IDLE && i_go && bad_go_c) ||
                      (state_q == S_RUN && !i_complete && timeout_c);
        ctx_we_d    = ctx_beat_c;
        st_ena_d    = (state_d == S_INIT) || (state_d == S_RD_ADDR);
        st_wea_d    = (state_d == S_INIT);
        st_din_d    = (state_d == S_INIT && k_d == '0) ? INIT_WORD : '0;
        rd_valid_d  = (state_d == S_RD_OUT);
        rd_last_d   = rd_valid_d && (k_d == n_last_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_busy        <= 1'b0;
            o_ctx_ready   <= 1'b0;
            o_start       <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_ctx_en      <= 1'b0;
            o_ctx_wea     <= 1'b0;
            o_ctx_addr    <= '0;
            o_ctx_data    <= '0;
            o_state_ena   <= 1'b0;
            o_state_wea   <= 1'b0;
            o_state_addra <= '0;
            o_state_dina  <= '0;
            o_rd_valid    <= 1'b0;
            o_rd_last     <= 1'b0;
            o_rd_data     <= '0;
        end else begin
            o_busy        <= busy_d;
            o_ctx_ready   <= ctx_ready_d;
            o_start       <= start_d;
            o_done        <= done_d;
            o_err         <= err_d;
            o_ctx_en      <= ctx_we_d;
            o_ctx_wea     <= ctx_we_d;
            o_state_ena   <= st_ena_d;
            o_state_wea   <= st_wea_d;
            o_state_addra <= k_d;
            o_state_dina  <= st_din_d;
            o_rd_valid    <= rd_valid_d;
            o_rd_last     <= rd_last_d;
            if (ctx_we_d) begin
                o_ctx_addr <= beats_q;
                o_ctx_data <= i_ctx_data;
            end
            if (state_q == S_RD_WAIT) o_rd_data <= i_state_dout;
        end
    end
endmodule

// File: tb/tb_qea_host_loader.sv
// Scoreboard bench for qea_host_loader: expected RAM writes and readback words are queued
// when a session is launched and popped as the DUT produces them.
module tb_qea_host_loader;
`ifdef QEA_HOST_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 50;
`else
    localparam int unsigned TB_TIMEOUT = 32'd16777216;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_go = 1'b0;
    logic [5:0]   i_qbit_num = '0;
    logic [15:0]  i_ins_num = '0;
    logic         i_ctx_valid = 1'b0;
    logic [63:0]  i_ctx_data = '0;
    logic [255:0] i_state_dout = '0;
    logic         i_complete = 1'b0;
    logic         i_rd_ready = 1'b0;
    logic         o_ctx_ready, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_start;
    logic         o_rd_valid, o_rd_last, o_busy, o_done, o_err;
    logic [15:0]  o_ctx_addr, o_state_addra;
    logic [63:0]  o_ctx_data;
    logic [255:0] o_state_dina, o_rd_data;
    logic [31:0]  o_cycles;

    int unsigned n_chk = 0, n_pass = 0;
    int unsigned start_cnt = 0, done_cnt = 0, ready_cnt = 0;
    bit          rd_toggle = 1'b0;
    logic [79:0]  ctx_exp [$];
    logic [271:0] st_exp [$];
    logic [256:0] rd_exp [$];
    logic [255:0] mem [int];
    logic [255:0] w0;

    qea_host_loader #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .i_state_dout(i_state_dout), .o_start(o_start),
        .i_complete(i_complete), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_rd_data(o_rd_data), .o_rd_last(o_rd_last), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_cycles(o_cycles)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // STATE RAM with one-cycle read latency
    always @(posedge clk) begin
        if (o_state_ena) begin
            if (o_state_wea) mem[int'(o_state_addra)] = o_state_dina;
            i_state_dout <= mem.exists(int'(o_state_addra)) ? mem[int'(o_state_addra)] : '0;
        end
    end

    initial forever begin
        step();
        i_rd_ready = rd_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: pops the scoreboard on every write/handshake and checks held data
    bit           hold_pend = 1'b0;
    logic [256:0] hold_val;
    always @(negedge clk) begin
        logic [79:0] ce; logic [271:0] se; logic [256:0] re;
        if (o_ctx_ready) ready_cnt++;
        if (o_start) start_cnt++;
        if (o_done) done_cnt++;
        if (o_ctx_en) begin
            if (ctx_exp.size() == 0) chk("ctx_unexpected_write", 256'(o_ctx_addr), 256'(0));
            else begin
                ce = ctx_exp.pop_front();
                chk("ctx_addr", 256'(o_ctx_addr), 256'(ce[79:64]));
                chk("ctx_data", 256'(o_ctx_data), 256'(ce[63:0]));
                chk("ctx_wea", 256'(o_ctx_wea), 256'(1));
            end
        end
        if (o_state_ena && o_state_wea) begin
            if (st_exp.size() == 0) chk("st_unexpected_write", 256'(o_state_addra), 256'(0));
            else begin
                se = st_exp.pop_front();
                chk("st_addr", 256'(o_state_addra), 256'(se[271:256]));
                chk("st_data", o_state_dina, se[255:0]);
            end
        end
        if (hold_pend) chk("rd_hold", 256'({o_rd_valid, o_rd_last, o_rd_data[253:0]}),
                           256'({1'b1, hold_val[256], hold_val[253:0]}));
        if (o_rd_valid && i_rd_ready) begin
            if (rd_exp.size() == 0) chk("rd_unexpected", 256'(o_rd_valid), 256'(0));
            else begin
                re = rd_exp.pop_front();
                chk("rd_data", o_rd_data, re[255:0]);
                chk("rd_last", 256'(o_rd_last), 256'(re[256]));
            end
        end
        hold_pend = o_rd_valid && !i_rd_ready;
        hold_val  = {o_rd_last, o_rd_data};
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, 256'({o_ctx_ready, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea,
            o_start, o_rd_valid, o_rd_last, o_busy, o_done, o_err}), 256'(0));
        chk({tag, "_addr"}, 256'({o_ctx_addr, o_state_addra, o_cycles}), 256'(0));
        chk({tag, "_ctx_data"}, 256'(o_ctx_data), 256'(0));
        chk({tag, "_dina"}, o_state_dina, 256'(0));
        chk({tag, "_rd_data"}, o_rd_data, 256'(0));
    endtask

    task automatic send_beat(input int idx, input bit gaps);
        logic [63:0] d;
        int b;
        if (gaps) repeat ($urandom_range(0, 3)) step();
        d = {$urandom, $urandom};
        i_ctx_valid = 1'b1;
        i_ctx_data  = d;
        b = 0;
        @(negedge clk);
        while (!o_ctx_ready && b < 50) begin @(negedge clk); b++; end
        chk("ctx_ready_wait", 256'(o_ctx_ready), 256'(1));
        if (o_ctx_ready) ctx_exp.push_back({16'(idx), d});
        step();
        i_ctx_valid = 1'b0;
    endtask

    task automatic push_init(input int n);
        for (int k = 0; k < n; k++) st_exp.push_back({16'(k), (k == 0) ? w0 : 256'(0)});
    endtask

    task automatic go(input int qbit, input int ins);
        i_qbit_num = 6'(qbit);
        i_ins_num  = 16'(ins);
        i_go = 1'b1;
        step();
        i_go = 1'b0;
    endtask

    task automatic wait_start(input int lim);
        int b = 0;
        @(negedge clk);
        while (!o_start && b < lim) begin @(negedge clk); b++; end
        chk("start_seen", 256'(o_start), 256'(1));
    endtask

    task automatic session(input int qbit, input int ins, input bit gaps, input bit stale,
                           input bit tog, input int run_cyc);
        int n, b;
        int unsigned s0, d0, r0;
        n = 1 << (qbit - 2);
        push_init(n);
        for (int k = 0; k < n; k++) rd_exp.push_back({1'(k == n - 1), (k == 0) ? w0 : 256'(0)});
        s0 = start_cnt; d0 = done_cnt; r0 = ready_cnt;
        rd_toggle  = tog;
        i_complete = stale;
        go(qbit, ins);
        for (int i = 0; i < ins; i++) send_beat(i, gaps);
        wait_start(n + 200);
        i_complete = 1'b0;
        repeat (run_cyc) @(posedge clk);
        #1 i_complete = 1'b1;
        b = 0;
        @(negedge clk);
        while (!o_done && b < 20 * n + 200) begin @(negedge clk); b++; end
        chk("done_seen", 256'(o_done), 256'(1));
        chk("busy_at_done", 256'(o_busy), 256'(1));
        chk("cycles", 256'(o_cycles), 256'(run_cyc));
        step();
        i_complete = 1'b0;
        rd_toggle  = 1'b0;
        @(negedge clk);
        chk("busy_idle", 256'(o_busy), 256'(0));
        chk("start_count", 256'(start_cnt - s0), 256'(1));
        chk("done_count", 256'(done_cnt - d0), 256'(1));
        if (ins == 0) chk("ctx_ready_never", 256'(ready_cnt - r0), 256'(0));
        chk("ctx_left", 256'(ctx_exp.size()), 256'(0));
        chk("st_left", 256'(st_exp.size()), 256'(0));
        chk("rd_left", 256'(rd_exp.size()), 256'(0));
        step();
    endtask

    initial begin
        w0 = 256'h4000_0000_0000_0000 << 192;
        repeat (3) @(negedge clk);
        check_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        session(13, 621, 1'b0, 1'b1, 1'b0, 100);
        session(3, 5, 1'b1, 1'b0, 1'b1, 37);
        session(3, 0, 1'b0, 1'b0, 1'b1, 7);
        session(2, 3, 1'b1, 1'b0, 1'b1, 1);

        // out-of-range qubit counts
        for (int t = 0; t < 2; t++) begin
            go((t == 0) ? 1 : 19, 4);
            @(negedge clk);
            chk("bad_qbit_err", 256'(o_err), 256'(1));
            chk("bad_qbit_busy", 256'(o_busy), 256'(0));
            @(negedge clk);
            chk("bad_qbit_err_pulse", 256'(o_err), 256'(0));
            step();
        end

        // reset in the middle of the context stream
        go(3, 5);
        send_beat(0, 1'b0);
        send_beat(1, 1'b0);
        step(); step();
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        ctx_exp.delete();
        step();
        rst_n = 1'b1;
        step();
        session(3, 5, 1'b1, 1'b0, 1'b0, 12);

`ifdef QEA_HOST_TIMEOUT_EN
        begin
            int b;
            push_init(2);
            go(3, 0);
            wait_start(200);
            b = 0;
            do begin @(negedge clk); b++; end while (!o_err && b < 200);
            chk("timeout_err", 256'(o_err), 256'(1));
            chk("timeout_latency", 256'(b), 256'(51));
            chk("timeout_cycles", 256'(o_cycles), 256'(50));
            chk("timeout_busy", 256'(o_busy), 256'(0));
            repeat (10) @(negedge clk);
            chk("timeout_no_rd", 256'(o_rd_valid), 256'(0));
            chk("timeout_st_left", 256'(st_exp.size()), 256'(0));
            step();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
